// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: skid-register states,
// EX/MEM payload layout and default payload width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } skid_state_t;

  localparam int REG_W    = 32;
  localparam int ADDR_W   = 32;
  localparam int WDATA_W  = 32;
  localparam int WNUM_W   = 5;
  localparam int WREG_W   = 1;
  localparam int ALUOP_W  = 5;

  localparam int REG_LSB   = 0;
  localparam int ADDR_LSB  = REG_LSB + REG_W;
  localparam int WDATA_LSB = ADDR_LSB + ADDR_W;
  localparam int WNUM_LSB  = WDATA_LSB + WDATA_W;
  localparam int WREG_LSB  = WNUM_LSB + WNUM_W;
  localparam int ALUOP_LSB = WREG_LSB + WREG_W;

  localparam int EXMEM_W = ALUOP_LSB + ALUOP_W;

endpackage

// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register with registered
// ready, synchronous flush and bubble clearing.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH           = EXMEM_W,
  parameter int CLEAR_ON_BUBBLE = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       count
);

  skid_state_t      state;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             in_xfer;
  logic             out_xfer;

  assign in_ready  = rst_n & (state != FULL);
  assign out_valid = (state != EMPTY);
  assign count     = state;
  assign in_xfer   = in_valid & in_ready;
  assign out_xfer  = out_ready & out_valid;

  assign out_data =
    ((CLEAR_ON_BUBBLE != 0) && (state == EMPTY))
      ? '0 : main_q;

  // Occupancy state and payload storage update
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (flush) begin
      state <= EMPTY;
      if (CLEAR_ON_BUBBLE != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else begin
      unique case (state)
        EMPTY: begin
          if (in_xfer) begin
            main_q <= in_data;
            state  <= BUSY;
          end
        end
        BUSY: begin
          unique case ({in_xfer, out_xfer})
            2'b11: main_q <= in_data;
            2'b10: begin
              skid_q <= in_data;
              state  <= FULL;
            end
            2'b01: state <= EMPTY;
            default: ;
          endcase
        end
        FULL: begin
          if (out_xfer) begin
            main_q <= skid_q;
            state  <= BUSY;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Scoreboard bench for pipe_skid_reg: directed cases
// followed by randomized valid/ready/flush traffic.
module tb_pipe_skid_reg;

  localparam int W = 107;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         flush;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   count;

  int n_chk  = 0;
  int n_fail = 0;
  int n_out  = 0;

  logic [W-1:0] exp_q[$];
  logic         rdy_exp   = 1'b0;
  logic         hold_prev = 1'b0;
  logic [W-1:0] prev_data = '0;

  pipe_skid_reg #(.WIDTH(W), .CLEAR_ON_BUBBLE(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference model: a FIFO of capacity two.
  always @(negedge rst_n) begin
    exp_q.delete();
    rdy_exp   = 1'b0;
    hold_prev = 1'b0;
  end

  always @(posedge clk) begin
    if (!rst_n) exp_q.delete();
    else if (flush) exp_q.delete();
    else if (in_valid && rdy_exp) exp_q.push_back(in_data);
  end

  // Monitor: compare occupancy, handshake and payload
  always @(negedge clk) begin
    int sz;
    logic [W-1:0] e;
    if (rst_n) begin
      sz = exp_q.size();
      chk("count", 128'(count), 128'(sz));
      chk("in_ready", 128'(in_ready), 128'(sz < 2));
      chk("out_valid", 128'(out_valid), 128'(sz > 0));
      if (hold_prev) chk("hold", 128'(out_data), 128'(prev_data));
      if (sz > 0) begin
        if (out_ready && !flush) begin
          e = exp_q.pop_front();
          chk("order", 128'(out_data), 128'(e));
          n_out++;
        end else begin
          chk("head", 128'(out_data), 128'(exp_q[0]));
        end
      end else begin
        chk("bubble", 128'(out_data), 128'(0));
      end
      rdy_exp   = (sz < 2);
      hold_prev = (sz > 0) && !out_ready && !flush;
      prev_data = out_data;
    end
  end

  task automatic step(input logic iv, input logic [W-1:0] d,
                      input logic ordy, input logic fl);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] rnd_data();
    logic [127:0] r;
    r = {$urandom, $urandom, $urandom, $urandom};
    return r[W-1:0];
  endfunction

  initial begin
    int base;
    logic drop;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    #3;
    chk("rst_count", 128'(count), 128'(0));
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_data", 128'(out_data), 128'(0));
    #20;
    rst_n = 1'b1;
    #1;
    chk("rel_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    chk("first_edge_count", 128'(count), 128'(0));

    // Single payload, one-cycle latency
    step(1'b1, W'(1), 1'b1, 1'b0);
    chk("lat_valid", 128'(out_valid), 128'(1));
    chk("lat_data", 128'(out_data), 128'(1));
    chk("lat_count", 128'(count), 128'(1));
    step(1'b0, '0, 1'b1, 1'b0);

    // Backpressure fills both entries
    step(1'b1, W'(10), 1'b0, 1'b0);
    step(1'b1, W'(11), 1'b0, 1'b0);
    step(1'b1, W'(12), 1'b0, 1'b0);
    chk("bp_count", 128'(count), 128'(2));
    chk("bp_in_ready", 128'(in_ready), 128'(0));
    chk("bp_data", 128'(out_data), 128'(10));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_next", 128'(out_data), 128'(11));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("bp_drained", 128'(count), 128'(0));

    // Full-rate stream
    base = n_out;
    drop = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (!in_ready) drop = 1'b1;
      step(1'b1, W'(i), 1'b1, 1'b0);
    end
    step(1'b0, '0, 1'b1, 1'b0);
    chk("stream_ready", 128'(drop), 128'(0));
    chk("stream_outs", 128'(n_out - base), 128'(100));

    // Flush while full, with a competing input
    step(1'b1, W'(5), 1'b0, 1'b0);
    step(1'b1, W'(6), 1'b0, 1'b0);
    step(1'b1, W'(7), 1'b1, 1'b1);
    chk("fl_count", 128'(count), 128'(0));
    chk("fl_valid", 128'(out_valid), 128'(0));
    chk("fl_data", 128'(out_data), 128'(0));
    step(1'b0, '0, 1'b1, 1'b0);
    chk("fl_no7", 128'(out_valid), 128'(0));

    // Asynchronous reset mid-operation
    step(1'b1, W'(3), 1'b0, 1'b0);
    in_valid = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 128'(out_valid), 128'(0));
    chk("arst_data", 128'(out_data), 128'(0));
    chk("arst_in_ready", 128'(in_ready), 128'(0));
    #1;
    rst_n = 1'b1;
    #1;
    chk("arst_rel_ready", 128'(in_ready), 128'(1));
    chk("arst_rel_count", 128'(count), 128'(0));
    step(1'b0, '0, 1'b0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), rnd_data(),
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 63) == 0));
    end
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, 1'b0);
    chk("final_empty", 128'(count), 128'(0));

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
